frame_bank_ctrl: RTL and testbench
==================================

# frame_bank_ctrl

Double-buffer scheduler for the frame RAM shared between the frame builder (writer, clk_fast domain) and the vector display (reader). It splits the RAM into two banks of DEPTH points, steers the writer to the back bank and the reader to the front bank, and swaps them only when the writer has finished a frame and the display has finished drawing. It owns the go/halt handshake that currently couples frame building to drawing, so the display never reads a half-written frame.

## Interface
Parameters:
- ADDRESSWIDTH, 16, width of all RAM addresses and counts
- DEPTH, 1000, points per bank; 2*DEPTH must be ≤ 2^ADDRESSWIDTH
- WDOG_CYCLES, 50_000_000, watchdog timeout in clk cycles (used only with FRAME_WATCHDOG_EN)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- wr_start  out  1  one-cycle pulse: writer begins a frame into the back bank
- wr_done  in  1  one-cycle pulse: writer finished the frame
- wr_count  in  ADDRESSWIDTH  points written; sampled on wr_done
- wr_we_in  in  1  writer write enable
- wr_adr_in  in  ADDRESSWIDTH  writer local address (0..DEPTH-1)
- wr_we_out  out  1  RAM write enable
- wr_adr_out  out  ADDRESSWIDTH  physical RAM write address
- rd_adr_in  in  ADDRESSWIDTH  display local address
- rd_adr_out  out  ADDRESSWIDTH  physical RAM read address
- go  out  1  one-cycle pulse: front bank valid, start drawing
- halt  in  1  one-cycle pulse: display finished a frame
- frame_len  out  ADDRESSWIDTH  point count of the front frame
- front_bank  out  1  bank currently read
- overflow  out  1  sticky: writer addressed ≥ DEPTH
- wdog_flag  out  1  sticky: watchdog fired

## Operation
- Bank base: 0 for bank 0, DEPTH for bank 1. wr_adr_out = base(~front_bank) + wr_adr_in; rd_adr_out = base(front_bank) + rd_adr_in. Both combinational from registered front_bank.
- wr_we_out = wr_we_in && wr_adr_in < DEPTH. Attempt with wr_adr_in ≥ DEPTH is suppressed and sets overflow.
- wr_count latched into back_len, clipped to DEPTH.
- States:
  - IDLE: entered on reset. Next cycle issue wr_start, go to FILL.
  - FILL: first frame only. On wr_done: swap, frame_len ← back_len, pulse go, pulse wr_start, go to SHOW.
  - SHOW: display drawing front; writer filling back. wr_done sets back_ready. On halt: if back_ready (or wr_done in same cycle), swap, pulse go and wr_start, clear back_ready; else go to STALL.
  - STALL: on wr_done swap, pulse go and wr_start, go to SHOW.
- halt outside SHOW, wr_done outside FILL/SHOW/STALL: ignored.
- Second wr_done while back_ready already set: back_len overwritten; no extra swap.

## Timing
- Reset values: wr_start 0, wr_we_out follows input gating, go 0, front_bank 0, frame_len 0, overflow 0, wdog_flag 0, state IDLE, back_ready 0.
- wr_start asserts the 2nd cycle after rst releases.
- Swap latency: go, front_bank and frame_len update on the edge after the triggering halt/wr_done (1 cycle). go is high in the first cycle rd_adr_out reflects the new bank.
- wr_start coincides with go on every swap.
- rst low mid-frame: all state returns to reset values on the next edge; partial frames discarded.

## Configuration
- FRAME_WATCHDOG_EN defined: counter runs in SHOW from go; reaching WDOG_CYCLES with no halt is treated as halt and sets wdog_flag. Counter clears on go and on reset.
- Undefined: no counter, wdog_flag tied 0, WDOG_CYCLES unused; a hung display stalls swapping indefinitely.

## Structure
- vector_pkg: FRAME_DEPTH constant (1000) and the bank_state_t enum (IDLE, FILL, SHOW, STALL).
- One sub-module: frame_watchdog (load/clear, count, timeout pulse), instantiated only under FRAME_WATCHDOG_EN.

## Test plan
- Reset release, wr_done after 20 cycles with wr_count=300 -> go pulse next cycle, front_bank=1, frame_len=300, wr_start pulsed with go.
- In SHOW, wr_done then halt 50 cycles later -> swap one cycle after halt, front_bank toggles, frame_len=new count.
- halt before wr_done -> STALL, no go; wr_done arrives -> go next cycle, bank swaps.
- halt and wr_done same cycle in SHOW -> single swap, single go, no STALL.
- wr_we_in=1, wr_adr_in=1000 -> wr_we_out=0, overflow=1 and stays 1 until reset; wr_adr_in=999 in bank 1 -> wr_adr_out=1999.
- With FRAME_WATCHDOG_EN, WDOG_CYCLES=100, back_ready set, no halt -> swap and go at 100 cycles after last go, wdog_flag=1; rst low mid-SHOW -> all outputs at reset values next edge.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared constants and FSM state type for the frame RAM double-buffer scheduler.
package vector_pkg;

  localparam int unsigned FRAME_DEPTH = 1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SHOW  = 2'd2,
    STALL = 2'd3
  } bank_state_t;

endpackage

// File: rtl/frame_watchdog.sv
// Display-hang watchdog: counts enabled cycles since the last clear and flags CYCLES of silence.
module frame_watchdog #(
  parameter int unsigned CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic timeout
);

  localparam logic [31:0] LAST = 32'(CYCLES - 1);

  logic [31:0] cnt;

  // Saturates at LAST so timeout stays a level the scheduler can act on.
  always_ff @(posedge clk) begin
    if (!rst)                      cnt <= '0;
    else if (clear)                cnt <= '0;
    else if (enable && cnt != LAST) cnt <= cnt + 32'd1;
  end

  // Must not depend on clear: clear is derived from timeout in the scheduler.
  assign timeout = enable && (cnt == LAST);

endmodule

// File: rtl/frame_bank_ctrl.sv
// Double-buffer scheduler for the shared frame RAM: bank steering, swap FSM, go/wr_start handshake.
// Optional display watchdog enabled by defining FRAME_WATCHDOG_EN.
module frame_bank_ctrl
  import vector_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH = 16,
  parameter int unsigned DEPTH        = FRAME_DEPTH,
  parameter int unsigned WDOG_CYCLES  = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    wr_start,
  input  logic                    wr_done,
  input  logic [ADDRESSWIDTH-1:0] wr_count,
  input  logic                    wr_we_in,
  input  logic [ADDRESSWIDTH-1:0] wr_adr_in,
  output logic                    wr_we_out,
  output logic [ADDRESSWIDTH-1:0] wr_adr_out,
  input  logic [ADDRESSWIDTH-1:0] rd_adr_in,
  output logic [ADDRESSWIDTH-1:0] rd_adr_out,
  output logic                    go,
  input  logic                    halt,
  output logic [ADDRESSWIDTH-1:0] frame_len,
  output logic                    front_bank,
  output logic                    overflow,
  output logic                    wdog_flag
);

  localparam logic [ADDRESSWIDTH-1:0] DEPTH_A = ADDRESSWIDTH'(DEPTH);

  bank_state_t state_q, state_d;
  logic                    front_q, front_d;
  logic [ADDRESSWIDTH-1:0] len_q, len_d;
  logic [ADDRESSWIDTH-1:0] back_len_q, back_len_d;
  logic                    ready_q, ready_d;
  logic                    go_q, go_d;
  logic                    start_q, start_d;
  logic                    ovf_q;
  logic                    swap;
  logic                    halt_eff;
  logic                    wr_bad;
  logic [ADDRESSWIDTH-1:0] done_len;

  // Bank steering is purely combinational off the registered front bank.
  assign wr_adr_out = (front_q ? '0 : DEPTH_A) + wr_adr_in;
  assign rd_adr_out = (front_q ? DEPTH_A : '0) + rd_adr_in;
  assign wr_bad     = wr_we_in && (wr_adr_in >= DEPTH_A);
  assign wr_we_out  = wr_we_in && !wr_bad;
  assign done_len   = (wr_count > DEPTH_A) ? DEPTH_A : wr_count;

`ifdef FRAME_WATCHDOG_EN
  logic wdog_timeout;
  logic wdog_q;

  frame_watchdog #(
    .CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .enable  (state_q == SHOW),
    .clear   (swap),
    .timeout (wdog_timeout)
  );

  assign halt_eff = halt || wdog_timeout;

  always_ff @(posedge clk) begin
    if (!rst)              wdog_q <= 1'b0;
    else if (wdog_timeout) wdog_q <= 1'b1;
  end

  assign wdog_flag = wdog_q;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES == 0);
  assign halt_eff    = halt;
  assign wdog_flag   = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    front_d    = front_q;
    len_d      = len_q;
    back_len_d = back_len_q;
    ready_d    = ready_q;
    go_d       = 1'b0;
    start_d    = 1'b0;
    swap       = 1'b0;

    unique case (state_q)
      IDLE: begin
        start_d = 1'b1;
        state_d = FILL;
      end
      FILL: begin
        if (wr_done) begin
          swap    = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (halt_eff) begin
          if (ready_q || wr_done) swap    = 1'b1;
          else                    state_d = STALL;
        end else if (wr_done) begin
          ready_d    = 1'b1;
          back_len_d = done_len;
        end
      end
      STALL: begin
        if (wr_done) begin
          swap    = 1'b1;
          state_d = SHOW;
        end
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle wr_done always carries the newest frame length.
    if (swap) begin
      front_d = !front_q;
      len_d   = wr_done ? done_len : back_len_q;
      go_d    = 1'b1;
      start_d = 1'b1;
      ready_d = 1'b0;
      if (wr_done) back_len_d = done_len;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      front_q    <= 1'b0;
      len_q      <= '0;
      back_len_q <= '0;
      ready_q    <= 1'b0;
      go_q       <= 1'b0;
      start_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      front_q    <= front_d;
      len_q      <= len_d;
      back_len_q <= back_len_d;
      ready_q    <= ready_d;
      go_q       <= go_d;
      start_q    <= start_d;
      if (wr_bad) ovf_q <= 1'b1;
    end
  end

  assign wr_start   = start_q;
  assign go         = go_q;
  assign frame_len  = len_q;
  assign front_bank = front_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_frame_bank_ctrl.sv
// Self-checking bench for frame_bank_ctrl: directed swap scenarios plus a randomized run
// against a frame-level reference model. Watchdog scenario runs when FRAME_WATCHDOG_EN is defined.
module tb_frame_bank_ctrl;

  localparam int AW = 16;
  localparam int D  = 1000;
  localparam int WD = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_start, wr_done, wr_we_in, wr_we_out, go, halt;
  logic          front_bank, overflow, wdog_flag;
  logic [AW-1:0] wr_count, wr_adr_in, wr_adr_out, rd_adr_in, rd_adr_out, frame_len;

  int checks = 0;
  int errors = 0;

  // Expected front bank, tracked by the scenarios from the swaps they cause.
  int exp_front = 0;

  frame_bank_ctrl #(
    .ADDRESSWIDTH (AW),
    .DEPTH        (D),
    .WDOG_CYCLES  (WD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_start   (wr_start),
    .wr_done    (wr_done),
    .wr_count   (wr_count),
    .wr_we_in   (wr_we_in),
    .wr_adr_in  (wr_adr_in),
    .wr_we_out  (wr_we_out),
    .wr_adr_out (wr_adr_out),
    .rd_adr_in  (rd_adr_in),
    .rd_adr_out (rd_adr_out),
    .go         (go),
    .halt       (halt),
    .frame_len  (frame_len),
    .front_bank (front_bank),
    .overflow   (overflow),
    .wdog_flag  (wdog_flag)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; inputs set before the call are sampled at that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int clip(input int n);
    return (n > D) ? D : n;
  endfunction

  task automatic pulse_done(input int n);
    wr_count = AW'(n);
    wr_done  = 1'b1;
    step();
    wr_done  = 1'b0;
  endtask

  task automatic pulse_halt();
    halt = 1'b1;
    step();
    halt = 1'b0;
  endtask

  // Reset, release, and expect a single wr_start pulse shortly after release.
  task automatic do_reset();
    int seen;
    wr_done = 0; halt = 0; wr_we_in = 0; wr_adr_in = 0; rd_adr_in = 0; wr_count = 0;
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    exp_front = 0;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (wr_start === 1'b1) seen++;
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL reset_wr_start pulses got %0d want 1", seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_done = 0; halt = 0; wr_count = 0;
    wr_we_in = 1; wr_adr_in = 5; rd_adr_in = 7;
    step(); step();
    checks++;
    if ({go, wr_start, front_bank, overflow, wdog_flag} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {go, wr_start, front_bank, overflow, wdog_flag});
    end
    checks++;
    if (frame_len !== 0) begin
      errors++; $display("FAIL reset_frame_len got %0d want 0", frame_len);
    end
    checks++;
    if (wr_we_out !== 1'b1 || wr_adr_out !== AW'(D + 5)) begin
      errors++; $display("FAIL reset_wr_path got we=%b adr=%0d want we=1 adr=%0d", wr_we_out, wr_adr_out, D + 5);
    end
    checks++;
    if (rd_adr_out !== 7) begin
      errors++; $display("FAIL reset_rd_path got %0d want 7", rd_adr_out);
    end
    wr_we_in = 0;
    do_reset();
  endtask

  task automatic test_first_frame();
    for (int i = 0; i < 20; i++) begin
      step();
      if (go !== 1'b0) begin
        checks++; errors++; $display("FAIL fill_early_go got 1 want 0");
      end
    end
    pulse_done(300);
    exp_front = 1;
    checks++;
    if (go !== 1 || wr_start !== 1 || front_bank !== 1 || frame_len !== 300) begin
      errors++;
      $display("FAIL first_swap got go=%b st=%b fb=%b len=%0d want 1 1 1 300", go, wr_start, front_bank, frame_len);
    end
    step();
    checks++;
    if (go !== 0 || wr_start !== 0) begin
      errors++; $display("FAIL first_swap_pulse_width got go=%b st=%b want 0 0", go, wr_start);
    end
  endtask

  task automatic test_show_swap();
    pulse_done(450);
    checks++;
    if (go !== 0 || front_bank !== 1'(exp_front)) begin
      errors++; $display("FAIL show_done_no_swap got go=%b fb=%b want 0 %0d", go, front_bank, exp_front);
    end
    for (int i = 0; i < 49; i++) step();
    pulse_halt();
    exp_front ^= 1;
    checks++;
    if (go !== 1 || wr_start !== 1 || front_bank !== 1'(exp_front) || frame_len !== 450) begin
      errors++;
      $display("FAIL show_swap got go=%b st=%b fb=%b len=%0d want 1 1 %0d 450", go, wr_start, front_bank, frame_len, exp_front);
    end
    checks++;
    if (rd_adr_out !== AW'((exp_front ? D : 0) + rd_adr_in)) begin
      errors++; $display("FAIL show_swap_rd_adr got %0d want %0d", rd_adr_out, (exp_front ? D : 0) + rd_adr_in);
    end
  endtask

  task automatic test_stall();
    int gos;
    pulse_halt();
    gos = (go === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (go === 1'b1) gos++;
    end
    checks++;
    if (gos != 0) begin
      errors++; $display("FAIL stall_no_go got %0d go pulses want 0", gos);
    end
    pulse_done(1234);
    exp_front ^= 1;
    checks++;
    if (go !== 1 || front_bank !== 1'(exp_front) || frame_len !== AW'(D)) begin
      errors++;
      $display("FAIL stall_release got go=%b fb=%b len=%0d want 1 %0d %0d", go, front_bank, frame_len, exp_front, D);
    end
  endtask

  task automatic test_same_cycle();
    int gos;
    step();
    wr_count = 77; wr_done = 1; halt = 1;
    step();
    wr_done = 0; halt = 0;
    exp_front ^= 1;
    gos = (go === 1'b1) ? 1 : 0;
    checks++;
    if (front_bank !== 1'(exp_front) || frame_len !== 77) begin
      errors++; $display("FAIL same_cycle_swap got fb=%b len=%0d want %0d 77", front_bank, frame_len, exp_front);
    end
    step();
    if (go === 1'b1) gos++;
    checks++;
    if (gos != 1) begin
      errors++; $display("FAIL same_cycle_go_count got %0d want 1", gos);
    end
    // Nothing ready now, so the next halt must stall.
    pulse_halt();
    checks++;
    if (go !== 0 || front_bank !== 1'(exp_front)) begin
      errors++; $display("FAIL same_cycle_ready_cleared got go=%b fb=%b want 0 %0d", go, front_bank, exp_front);
    end
    pulse_done(5);
    exp_front ^= 1;
  endtask

  task automatic test_double_done();
    step();
    pulse_done(10);
    step();
    pulse_done(20);
    checks++;
    if (go !== 0) begin
      errors++; $display("FAIL double_done_extra_swap got go=1 want 0");
    end
    step();
    pulse_halt();
    exp_front ^= 1;
    checks++;
    if (go !== 1 || front_bank !== 1'(exp_front) || frame_len !== 20) begin
      errors++; $display("FAIL double_done_len got go=%b fb=%b len=%0d want 1 %0d 20", go, front_bank, frame_len, exp_front);
    end
  endtask

  task automatic test_overflow();
    checks++;
    if (overflow !== 0) begin
      errors++; $display("FAIL overflow_pre got 1 want 0");
    end
    wr_we_in = 1; wr_adr_in = AW'(D);
    #1;
    checks++;
    if (wr_we_out !== 0) begin
      errors++; $display("FAIL overflow_gate got we=%b want 0", wr_we_out);
    end
    step();
    wr_adr_in = AW'(D - 1);
    #1;
    checks++;
    if (overflow !== 1 || wr_we_out !== 1 || wr_adr_out !== AW'((exp_front ? 0 : D) + D - 1)) begin
      errors++;
      $display("FAIL overflow_set got ovf=%b we=%b adr=%0d want 1 1 %0d", overflow, wr_we_out, wr_adr_out,
               (exp_front ? 0 : D) + D - 1);
    end
    wr_we_in = 0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (overflow !== 1) begin
      errors++; $display("FAIL overflow_sticky got 0 want 1");
    end
  endtask

  // Bring the bench into a known back-bank-is-front-0 state for the 1999 boundary.
  task automatic test_bank1_boundary();
    if (exp_front != 0) begin
      pulse_done(3);
      step();
      pulse_halt();
      exp_front ^= 1;
    end
    wr_we_in = 1; wr_adr_in = AW'(D - 1);
    #1;
    checks++;
    if (front_bank !== 0 || wr_adr_out !== AW'(2 * D - 1)) begin
      errors++; $display("FAIL bank1_top_adr got fb=%b adr=%0d want 0 %0d", front_bank, wr_adr_out, 2 * D - 1);
    end
    wr_we_in = 0;
  endtask

  // Frame-level reference: a completed back frame may be pending, and the display may be waiting.
  task automatic test_random();
    int pending, waiting, m_front, m_len, m_ovf, since_go, errs_before;
    int n, we, adr, rda, dn, hl, swap, halt_eff;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    pulse_done(600);
    m_front = 1; m_len = 600; pending = -1; waiting = 0; m_ovf = 0; since_go = 0;
    errs_before = errors;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      dn  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      hl  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      n   = $urandom_range(0, 1200);
      we  = $urandom_range(0, 1);
      adr = (we != 0 && $urandom_range(0, 99) == 0) ? $urandom_range(D, D + 100) : $urandom_range(0, D - 1);
      rda = $urandom_range(0, D - 1);
      wr_done = 1'(dn); halt = 1'(hl); wr_count = AW'(n);
      wr_we_in = 1'(we); wr_adr_in = AW'(adr); rd_adr_in = AW'(rda);
      halt_eff = hl;
`ifdef FRAME_WATCHDOG_EN
      if (!waiting && since_go == WD - 1) halt_eff = 1;
`endif
      swap = 0;
      if (waiting) begin
        if (dn) begin swap = 1; m_len = clip(n); waiting = 0; end
      end else if (halt_eff) begin
        if (dn)               begin swap = 1; m_len = clip(n); end
        else if (pending >= 0) begin swap = 1; m_len = pending; end
        else                   waiting = 1;
      end else if (dn) begin
        pending = clip(n);
      end
      if (swap) begin m_front ^= 1; pending = -1; since_go = 0; end
      else      since_go++;
      if (we != 0 && adr >= D) m_ovf = 1;
      step();
      checks++;
      if (go !== 1'(swap) || wr_start !== 1'(swap) || front_bank !== 1'(m_front) || frame_len !== AW'(m_len)) begin
        errors++;
        $display("FAIL rand_ctrl cyc %0d got go=%b st=%b fb=%b len=%0d want %0d %0d %0d %0d",
                 cyc, go, wr_start, front_bank, frame_len, swap, swap, m_front, m_len);
      end
      checks++;
      if (rd_adr_out !== AW'((m_front ? D : 0) + rda) || wr_adr_out !== AW'((m_front ? 0 : D) + adr) ||
          wr_we_out !== 1'(we != 0 && adr < D) || overflow !== 1'(m_ovf)) begin
        errors++;
        $display("FAIL rand_path cyc %0d got rd=%0d wr=%0d we=%b ovf=%b", cyc, rd_adr_out, wr_adr_out, wr_we_out, overflow);
      end
      if (errors - errs_before > 10) break;
    end
    wr_done = 0; halt = 0; wr_we_in = 0;
    exp_front = m_front;
`ifndef FRAME_WATCHDOG_EN
    checks++;
    if (wdog_flag !== 0) begin
      errors++; $display("FAIL rand_wdog_off got 1 want 0");
    end
`endif
  endtask

  task automatic test_reset_mid();
    pulse_done(40);
    wr_we_in = 1; wr_adr_in = AW'(D + 3);
    step();
    wr_we_in = 0;
    rst = 1'b0;
    step();
    checks++;
    if ({go, wr_start, front_bank, overflow, wdog_flag} !== 5'b0 || frame_len !== 0) begin
      errors++;
      $display("FAIL reset_mid got flags=%b len=%0d want 00000 0", {go, wr_start, front_bank, overflow, wdog_flag}, frame_len);
    end
    rst = 1'b1;
  endtask

`ifdef FRAME_WATCHDOG_EN
  task automatic test_watchdog();
    int n;
    do_reset();
    pulse_done(200);
    n = 0;
    pulse_done(60);
    n++;
    while (go !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n != WD || frame_len !== 60 || wdog_flag !== 1) begin
      errors++; $display("FAIL watchdog_swap got cycles=%0d len=%0d flag=%b want %0d 60 1", n, frame_len, wdog_flag, WD);
    end
    rst = 1'b0;
    step();
    checks++;
    if (wdog_flag !== 0 || go !== 0 || front_bank !== 0) begin
      errors++; $display("FAIL watchdog_reset got flag=%b go=%b fb=%b want 0 0 0", wdog_flag, go, front_bank);
    end
    rst = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_show_swap();
    test_stall();
    test_same_cycle();
    test_double_done();
    test_overflow();
    test_bank1_boundary();
    test_random();
    test_reset_mid();
`ifdef FRAME_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
